// File: rtl/sha3_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sha3_pkg
// Description : Shared constants and padder state encoding for the SHA3-256
//               message front-end.
// Revision    : 1.0 - initial release
// ============================================================================
package sha3_pkg;

    localparam int RATE_BYTES      = 136;
    localparam int RATE_BITS       = 1088;
    localparam int WORDS_PER_BLOCK = 17;

    localparam logic [7:0] SHA3_DSUF    = 8'h06;
    localparam logic [7:0] SHA3_PAD_END = 8'h80;

    typedef enum logic [2:0] {
        ST_FILL    = 3'd0,
        ST_PAD     = 3'd1,
        ST_ISSUE   = 3'd2,
        ST_WAIT_LO = 3'd3,
        ST_WAIT_HI = 3'd4
    } pad_state_t;

endpackage
`default_nettype wire

// File: rtl/sha3_pad_gen.sv
`default_nettype none
// ============================================================================
// Module      : sha3_pad_gen
// Description : Builds the rate-wide SHA-3 pad mask: domain byte at byte p,
//               final bit in byte 135 (both land in byte 135 when p == 135).
// Revision    : 1.0 - initial release
// ============================================================================
module sha3_pad_gen
    import sha3_pkg::*;
(
    input  logic [7:0]           i_p,
    output logic [RATE_BITS-1:0] o_pad_mask
);

    logic [RATE_BITS-1:0] w_dsuf_mask;
    logic [RATE_BITS-1:0] w_end_mask;

    // Byte i occupies bits [RATE_BITS-1-8i -: 8], so a right shift by 8p places byte p.
    assign w_dsuf_mask = {SHA3_DSUF, {(RATE_BITS-8){1'b0}}} >> {i_p, 3'b000};
    assign w_end_mask  = {{(RATE_BITS-8){1'b0}}, SHA3_PAD_END};
    assign o_pad_mask  = w_dsuf_mask | w_end_mask;

endmodule
`default_nettype wire

// File: rtl/sha3_padder.sv
`default_nettype none
// ============================================================================
// Module      : sha3_padder
// Description : Packs a 64-bit message word stream into 1088-bit rate blocks,
//               applies SHA-3 padding and drives the core block handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module sha3_padder
    import sha3_pkg::RATE_BITS, sha3_pkg::WORDS_PER_BLOCK, sha3_pkg::pad_state_t,
           sha3_pkg::ST_FILL, sha3_pkg::ST_PAD, sha3_pkg::ST_ISSUE,
           sha3_pkg::ST_WAIT_LO, sha3_pkg::ST_WAIT_HI;
#(
    parameter int RATE_BYTES = 136
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [63:0]          in_data,
    input  logic [3:0]           in_bytes,
    input  logic                 in_last,
    output logic [RATE_BITS-1:0] blk_data,
    output logic                 blk_start,
    output logic                 blk_last,
    input  logic                 core_ready,
    output logic                 msg_done
);

    localparam logic [7:0] c_RATE_BYTES = 8'(RATE_BYTES);
    localparam logic [4:0] c_LAST_WORD  = 5'(WORDS_PER_BLOCK - 1);

    pad_state_t           r_state, w_state_nxt;
    logic [RATE_BITS-1:0] r_buf, w_buf_nxt;
    logic [4:0]           r_wcnt, w_wcnt_nxt;
    logic [7:0]           r_p, w_p_nxt;
    logic                 r_pad_pending, w_pad_pending_nxt;
    logic                 r_blk_last, w_blk_last_nxt;

    logic [3:0]           w_nbytes;
    logic [63:0]          w_keep;
    logic [63:0]          w_word;
    logic [RATE_BITS-1:0] w_word_placed;
    logic [7:0]           w_p_last;
    logic [RATE_BITS-1:0] w_pad_mask;

    // Only a last word may be short; out-of-range counts saturate at a full word.
    assign w_nbytes = (!in_last || (in_bytes > 4'd8)) ? 4'd8 : in_bytes;
    assign w_keep   = ~({64{1'b1}} >> {w_nbytes, 3'b000});
    assign w_word   = in_data & w_keep;

    // The buffer is all-zero beyond the fill point, so OR-ing the slot in is enough.
    assign w_word_placed = {w_word, {(RATE_BITS-64){1'b0}}} >> {r_wcnt, 6'b000000};
    assign w_p_last      = {r_wcnt, 3'b000} + {4'b0000, w_nbytes};

    sha3_pad_gen u_pad_gen (
        .i_p        (r_p),
        .o_pad_mask (w_pad_mask)
    );

    always_comb begin
        w_state_nxt       = r_state;
        w_buf_nxt         = r_buf;
        w_wcnt_nxt        = r_wcnt;
        w_p_nxt           = r_p;
        w_pad_pending_nxt = r_pad_pending;
        w_blk_last_nxt    = r_blk_last;
        in_ready          = 1'b0;
        blk_start         = 1'b0;
        msg_done          = 1'b0;

        case (r_state)
            ST_FILL: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_buf_nxt  = r_buf | w_word_placed;
                    w_wcnt_nxt = r_wcnt + 5'd1;
                    if (in_last) begin
                        w_p_nxt = w_p_last;
                        if (w_p_last < c_RATE_BYTES) begin
                            w_state_nxt = ST_PAD;
                        end else begin
                            // Message filled the block exactly: pad goes in a block of its own.
                            w_pad_pending_nxt = 1'b1;
                            w_blk_last_nxt    = 1'b0;
                            w_state_nxt       = ST_ISSUE;
                        end
                    end else if (r_wcnt == c_LAST_WORD) begin
                        w_blk_last_nxt = 1'b0;
                        w_state_nxt    = ST_ISSUE;
                    end
                end
            end
            ST_PAD: begin
                w_buf_nxt      = r_buf ^ w_pad_mask;
                w_blk_last_nxt = 1'b1;
                w_state_nxt    = ST_ISSUE;
            end
            ST_ISSUE: begin
                blk_start = core_ready;
                if (core_ready) begin
                    w_state_nxt = ST_WAIT_LO;
                end
            end
            ST_WAIT_LO: begin
                if (!core_ready) begin
                    w_state_nxt = ST_WAIT_HI;
                end
            end
            ST_WAIT_HI: begin
                if (core_ready) begin
                    w_buf_nxt = '0;
                    if (r_blk_last) begin
                        msg_done       = 1'b1;
                        w_wcnt_nxt     = 5'd0;
                        w_blk_last_nxt = 1'b0;
                        w_state_nxt    = ST_FILL;
                    end else if (r_pad_pending) begin
                        w_pad_pending_nxt = 1'b0;
                        w_p_nxt           = 8'd0;
                        w_state_nxt       = ST_PAD;
                    end else begin
                        w_wcnt_nxt  = 5'd0;
                        w_state_nxt = ST_FILL;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_FILL;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= ST_FILL;
            r_buf         <= '0;
            r_wcnt        <= 5'd0;
            r_p           <= 8'd0;
            r_pad_pending <= 1'b0;
            r_blk_last    <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_buf         <= w_buf_nxt;
            r_wcnt        <= w_wcnt_nxt;
            r_p           <= w_p_nxt;
            r_pad_pending <= w_pad_pending_nxt;
            r_blk_last    <= w_blk_last_nxt;
        end
    end

    assign blk_data = r_buf;
    assign blk_last = r_blk_last;

endmodule
`default_nettype wire

// File: tb/tb_sha3_padder.sv
`default_nettype none
// ============================================================================
// Module      : tb_sha3_padder
// Description : Self-checking bench for sha3_padder with a behavioural core
//               handshake model and directed message-length vectors.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sha3_padder;

    localparam int c_CORE_LAT = 6;
    localparam int c_TMO      = 3000;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [63:0]   in_data;
    logic [3:0]    in_bytes;
    logic          in_last;
    logic [1087:0] blk_data;
    logic          blk_start;
    logic          blk_last;
    logic          core_ready;
    logic          msg_done;

    sha3_padder #(.RATE_BYTES(136)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_bytes   (in_bytes),
        .in_last    (in_last),
        .blk_data   (blk_data),
        .blk_start  (blk_start),
        .blk_last   (blk_last),
        .core_ready (core_ready),
        .msg_done   (msg_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Core stand-in: drops ready after start, raises it again after a fixed latency.
    logic          r_core_busy = 1'b0;
    int            r_core_cnt  = 0;
    logic          core_hold   = 1'b0;
    logic [1087:0] cap_data[$];
    logic          cap_last[$];
    int            n_start = 0;
    int            n_done  = 0;

    assign core_ready = !r_core_busy && !core_hold;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            r_core_busy <= 1'b0;
            r_core_cnt  <= 0;
        end else begin
            if (blk_start) begin
                r_core_busy <= 1'b1;
                r_core_cnt  <= c_CORE_LAT;
                cap_data.push_back(blk_data);
                cap_last.push_back(blk_last);
                n_start <= n_start + 1;
            end else if (r_core_busy) begin
                if (r_core_cnt == 0) r_core_busy <= 1'b0;
                else                 r_core_cnt  <= r_core_cnt - 1;
            end
            if (msg_done) n_done <= n_done + 1;
        end
    end

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    function automatic logic [7:0] get_byte(input logic [1087:0] b, input int i);
        return b[1087-8*i -: 8];
    endfunction

    task automatic chk_blk(input string name, input logic [1087:0] act, input logic [1087:0] exp);
        int bad_i;
        bad_i = -1;
        for (int i = 135; i >= 0; i--)
            if (get_byte(act, i) !== get_byte(exp, i)) bad_i = i;
        n_chk++;
        if (bad_i < 0) n_pass++;
        else $display("FAIL %s: byte %0d got 0x%0h, expected 0x%0h", name, bad_i,
                      get_byte(act, bad_i), get_byte(exp, bad_i));
    endtask

    function automatic logic [7:0] msg_byte(input int i);
        return 8'(i * 7 + 3);
    endfunction

    // Reference padded block k of a len-byte message built from msg_byte().
    function automatic logic [1087:0] exp_block(input int len, input int k);
        logic [1087:0] b;
        int nblk;
        int g;
        b    = '0;
        nblk = len / 136 + 1;
        for (int i = 0; i < 136; i++) begin
            g = k * 136 + i;
            if (g < len) b[1087-8*i -: 8] = msg_byte(g);
        end
        if (k == nblk - 1) begin
            b[1087-8*(len%136) -: 8] = b[1087-8*(len%136) -: 8] ^ 8'h06;
            b[7:0] = b[7:0] | 8'h80;
        end
        return b;
    endfunction

    task automatic send_word(input logic [63:0] d, input logic [3:0] nb, input logic last,
                             output bit to);
        int t;
        t         = 0;
        in_valid  = 1'b1;
        in_data   = d;
        in_bytes  = nb;
        in_last   = last;
        while (!in_ready && t < c_TMO) begin
            @(negedge clk);
            t++;
        end
        to = !in_ready;
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic send_msg(input int len, output bit to);
        int  nw;
        int  nb;
        bit  t1;
        logic [63:0] d;
        nw = (len == 0) ? 1 : (len + 7) / 8;
        to = 1'b0;
        for (int w = 0; w < nw; w++) begin
            nb = (w == nw - 1) ? len - 8 * w : 8;
            for (int b = 0; b < 8; b++)
                d[63-8*b -: 8] = (b < nb) ? msg_byte(8 * w + b) : 8'hA5;
            send_word(d, 4'(nb), (w == nw - 1), t1);
            if (t1) to = 1'b1;
        end
    endtask

    task automatic wait_done(input int target, output bit to);
        int t;
        t = 0;
        while (n_done < target && t < c_TMO) begin
            @(negedge clk);
            t++;
        end
        to = (n_done < target);
    endtask

    typedef struct {
        int         len;
        int         nblk;
        int         pad_idx;
        logic [7:0] pad_val;
        logic [7:0] b135;
    } vec_t;

    vec_t vecs[13];

    initial begin
        bit  to;
        int  base;
        int  done0;
        int  start0;
        int  bad;
        int  nb;
        logic [1087:0] snap;

        vecs[0]  = '{0,   1, 0,   8'h06, 8'h80};
        vecs[1]  = '{3,   1, 3,   8'h06, 8'h80};
        vecs[2]  = '{7,   1, 7,   8'h06, 8'h80};
        vecs[3]  = '{8,   1, 8,   8'h06, 8'h80};
        vecs[4]  = '{64,  1, 64,  8'h06, 8'h80};
        vecs[5]  = '{127, 1, 127, 8'h06, 8'h80};
        vecs[6]  = '{128, 1, 128, 8'h06, 8'h80};
        vecs[7]  = '{134, 1, 134, 8'h06, 8'h80};
        vecs[8]  = '{135, 1, 135, 8'h86, 8'h86};
        vecs[9]  = '{136, 2, 0,   8'h06, 8'h80};
        vecs[10] = '{137, 2, 1,   8'h06, 8'h80};
        vecs[11] = '{200, 2, 64,  8'h06, 8'h80};
        vecs[12] = '{272, 3, 0,   8'h06, 8'h80};

        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        in_bytes = 4'd0;
        in_last  = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        chk("rst_in_ready",  64'(in_ready),  64'd1);
        chk("rst_blk_start", 64'(blk_start), 64'd0);
        chk("rst_blk_last",  64'(blk_last),  64'd0);
        chk("rst_msg_done",  64'(msg_done),  64'd0);
        chk("rst_blk_data",  64'(|blk_data), 64'd0);

        // Directed lengths around word and block boundaries.
        for (int v = 0; v < 13; v++) begin
            base  = cap_data.size();
            done0 = n_done;
            start0 = n_start;
            send_msg(vecs[v].len, to);
            chk($sformatf("v%0d_send_tmo", vecs[v].len), 64'(to), 64'd0);
            wait_done(done0 + 1, to);
            chk($sformatf("v%0d_done_tmo", vecs[v].len), 64'(to), 64'd0);
            chk($sformatf("v%0d_nstart", vecs[v].len), 64'(n_start - start0), 64'(vecs[v].nblk));
            nb = cap_data.size() - base;
            if (nb > vecs[v].nblk) nb = vecs[v].nblk;
            for (int k = 0; k < nb; k++) begin
                chk_blk($sformatf("v%0d_blk%0d", vecs[v].len, k), cap_data[base+k],
                        exp_block(vecs[v].len, k));
                chk($sformatf("v%0d_last%0d", vecs[v].len, k), 64'(cap_last[base+k]),
                    64'(k == vecs[v].nblk - 1));
            end
            if (nb == vecs[v].nblk) begin
                chk($sformatf("v%0d_padbyte", vecs[v].len),
                    64'(get_byte(cap_data[base+nb-1], vecs[v].pad_idx)), 64'(vecs[v].pad_val));
                chk($sformatf("v%0d_byte135", vecs[v].len),
                    64'(get_byte(cap_data[base+nb-1], 135)), 64'(vecs[v].b135));
            end
            @(negedge clk);
        end

        // "abc" with junk in the unused bytes.
        base  = cap_data.size();
        done0 = n_done;
        send_word(64'h616263DEADBEEF55, 4'd3, 1'b1, to);
        wait_done(done0 + 1, to);
        chk("abc_done_tmo", 64'(to), 64'd0);
        if (cap_data.size() > base) begin
            chk("abc_head", 64'(cap_data[base][1087:1056]), 64'h61626306);
            chk("abc_mid",  64'(|cap_data[base][1055:8]),   64'd0);
            chk("abc_tail", 64'(cap_data[base][7:0]),       64'h80);
            chk("abc_last", 64'(cap_last[base]),            64'd1);
        end else begin
            chk("abc_captured", 64'(cap_data.size() - base), 64'd1);
        end
        @(negedge clk);

        // 136 bytes: input must stay blocked across both blocks.
        done0 = n_done;
        send_msg(136, to);
        bad = 0;
        for (int t = 0; t < c_TMO && n_done < done0 + 1; t++) begin
            if (in_ready) bad++;
            @(negedge clk);
        end
        chk("x136_ready_low", 64'(bad), 64'd0);
        chk("x136_ready_back", 64'(in_ready), 64'd1);
        chk("x136_done", 64'(n_done - done0), 64'd1);

        // Backpressure held in ISSUE.
        base   = cap_data.size();
        done0  = n_done;
        start0 = n_start;
        core_hold = 1'b1;
        send_msg(3, to);
        @(negedge clk);
        snap     = blk_data;
        in_valid = 1'b1;
        in_data  = 64'h0123456789ABCDEF;
        in_last  = 1'b0;
        bad = 0;
        for (int t = 0; t < 10; t++) begin
            if (blk_start || in_ready || (blk_data !== snap)) bad++;
            @(negedge clk);
        end
        chk("bp_hold_stable", 64'(bad), 64'd0);
        chk("bp_no_start", 64'(n_start - start0), 64'd0);
        in_valid  = 1'b0;
        core_hold = 1'b0;
        #1;
        chk("bp_release_start", 64'(blk_start), 64'd1);
        wait_done(done0 + 1, to);
        chk("bp_done_tmo", 64'(to), 64'd0);
        if (cap_data.size() > base) chk_blk("bp_blk", cap_data[base], exp_block(3, 0));
        chk("bp_nstart", 64'(n_start - start0), 64'd1);
        @(negedge clk);

        // Asynchronous reset while waiting on the core.
        send_msg(3, to);
        for (int t = 0; t < 200 && !blk_start; t++) @(negedge clk);
        chk("mr_start_seen", 64'(blk_start), 64'd1);
        @(posedge clk);
        #1;
        chk("mr_pre_last", 64'(blk_last), 64'd1);
        rst = 1'b1;
        #1;
        chk("mr_in_ready",  64'(in_ready),  64'd1);
        chk("mr_blk_start", 64'(blk_start), 64'd0);
        chk("mr_blk_last",  64'(blk_last),  64'd0);
        chk("mr_msg_done",  64'(msg_done),  64'd0);
        chk("mr_blk_data",  64'(|blk_data), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        base  = cap_data.size();
        done0 = n_done;
        send_word(64'h616263DEADBEEF55, 4'd3, 1'b1, to);
        wait_done(done0 + 1, to);
        chk("mr_abc_done_tmo", 64'(to), 64'd0);
        if (cap_data.size() > base) begin
            chk("mr_abc_head", 64'(cap_data[base][1087:1056]), 64'h61626306);
            chk("mr_abc_rest", 64'(|cap_data[base][1055:8]),   64'd0);
            chk("mr_abc_tail", 64'(cap_data[base][7:0]),       64'h80);
        end
        chk("mr_abc_nblk", 64'(cap_data.size() - base), 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
